// File: rtl/ysyx_22050019_icache.sv
// Direct-mapped, read-only instruction cache sitting between the IFU fetch
// port (AXI-lite read slave, s_axi_*) and the arbiter's instruction read
// channel (AXI-lite read master, m_axi_*).
//   clk, rst_n        : clock, asynchronous active-low reset
//   fence_i           : pulse, invalidates every line
//   s_axi_ar*/s_axi_r*: IFU request / response (64-bit aligned word)
//   m_axi_ar*/m_axi_r*: line refill, two 64-bit beats per 16-byte line
//   hit_cnt, miss_cnt : wrapping event counters since reset
module ysyx_22050019_icache #(
  parameter int NSETS  = 16,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fence_i,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [1:0]        s_axi_rresp,
  output logic [63:0]       s_axi_rdata,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [1:0]        m_axi_rresp,
  input  logic [63:0]       m_axi_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_RESP
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [NSETS-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag   [NSETS];
  logic [63:0]       r_word0 [NSETS];
  logic [63:0]       r_word1 [NSETS];
  logic [63:0]       r_buf0;
  logic              r_beat;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_fence_pend;
  logic [63:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_ar_hs;
  logic              w_beat_done;
  logic              w_last_beat;
  logic              w_commit;
  logic [1:0]        w_final_resp;

  assign w_idx        = r_addr[3+IDX_W:4];
  assign w_tag        = r_addr[ADDR_W-1:4+IDX_W];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ar_hs      = (r_state == S_IDLE) && s_axi_arvalid && !fence_i;
  assign w_beat_done  = (r_state == S_MISS_R) && m_axi_rvalid;
  assign w_last_beat  = w_beat_done && r_beat;
  assign w_final_resp = r_err ? r_err_code : m_axi_rresp;
  // A fence in the commit cycle (or earlier in this refill) keeps the line invalid.
  assign w_commit     = w_last_beat && !r_err && (m_axi_rresp == 2'b00)
                        && !r_fence_pend && !fence_i;

  // Handshake outputs decode straight from the state register so reset
  // drops them asynchronously.
  assign s_axi_arready = (r_state == S_IDLE) && !fence_i;
  assign s_axi_rvalid  = (r_state == S_RESP);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign m_axi_arvalid = (r_state == S_MISS_AR);
  assign m_axi_rready  = (r_state == S_MISS_R);
  assign m_axi_araddr  = (r_state == S_MISS_AR) ? {r_addr[ADDR_W-1:4], r_beat, 3'b000} : '0;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_ar_hs) w_next = S_LOOKUP;
      S_LOOKUP:  w_next = w_hit ? S_RESP : S_MISS_AR;
      S_MISS_AR: if (m_axi_arready) w_next = S_MISS_R;
      S_MISS_R:  if (m_axi_rvalid) w_next = r_beat ? S_RESP : S_MISS_AR;
      S_RESP:    if (s_axi_rready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_valid <= '0;
    else if (fence_i)  r_valid <= '0;
    else if (w_commit) r_valid[w_idx] <= 1'b1;
  end

  // Line storage needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_tag[w_idx]   <= w_tag;
      r_word0[w_idx] <= r_buf0;
      r_word1[w_idx] <= m_axi_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_buf0       <= '0;
      r_beat       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
      r_fence_pend <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_ar_hs) r_addr <= s_axi_araddr;

      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          r_rdata   <= r_addr[3] ? r_word1[w_idx] : r_word0[w_idx];
          r_rresp   <= 2'b00;
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
          r_beat     <= 1'b0;
          r_err      <= 1'b0;
          r_err_code <= '0;
        end
      end

      if (w_beat_done) begin
        if (!r_err && (m_axi_rresp != 2'b00)) begin
          r_err      <= 1'b1;
          r_err_code <= m_axi_rresp;
        end
        if (!r_beat) begin
          r_buf0 <= m_axi_rdata;
          r_beat <= 1'b1;
        end else begin
          // Beat 1 is still on the bus, so word 1 is taken from m_axi_rdata.
          r_rdata <= r_addr[3] ? m_axi_rdata : r_buf0;
          r_rresp <= w_final_resp;
        end
      end

      if (fence_i && ((r_state == S_MISS_AR) || (r_state == S_MISS_R)))
        r_fence_pend <= 1'b1;
      else if ((r_state == S_RESP) && s_axi_rready)
        r_fence_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ysyx_22050019_icache.sv
module tb_ysyx_22050019_icache;
  logic        clk;
  logic        rst_n;
  logic        fence_i;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_araddr;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [1:0]  s_axi_rresp;
  logic [63:0] s_axi_rdata;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [1:0]  m_axi_rresp;
  logic [63:0] m_axi_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  ysyx_22050019_icache #(.NSETS(16), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .fence_i(fence_i),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .s_axi_rresp(s_axi_rresp),
    .s_axi_rdata(s_axi_rdata), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rresp(m_axi_rresp), .m_axi_rdata(m_axi_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model behind the arbiter: zero-wait unless mem_arready is held low.
  logic [63:0] ar_log [64];
  int          ar_cnt   = 0;
  logic [63:0] err_addr = '1;
  logic        mem_arready;
  logic        hs_ar, hs_r;
  logic [63:0] ar_addr_s;

  assign m_axi_arready = mem_arready;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0297;
    if (a == 64'h8000_0008) return 64'h1111_2222_3333_4444;
    return {~a[31:0], a[31:0]};
  endfunction

  initial begin
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = '0;
    m_axi_rresp  = '0;
    mem_arready  = 1'b1;
    forever begin
      @(negedge clk);
      hs_ar     = m_axi_arvalid && mem_arready;
      hs_r      = m_axi_rvalid && m_axi_rready;
      ar_addr_s = m_axi_araddr;
      @(posedge clk);
      #1;
      if (hs_r) m_axi_rvalid = 1'b0;
      if (hs_ar) begin
        if (ar_cnt < 64) ar_log[ar_cnt] = ar_addr_s;
        ar_cnt++;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(ar_addr_s);
        m_axi_rresp  = (ar_addr_s == err_addr) ? 2'b10 : 2'b00;
      end
    end
  end

  // One IFU fetch. lat counts cycles from the AR handshake cycle to the
  // first cycle with rvalid; hold keeps rready low that many cycles.
  task automatic fetch(input logic [63:0] a, input int hold,
                       output logic [63:0] d, output logic [1:0] r, output int lat);
    int n;
    d = '0; r = '0; lat = -1;
    @(negedge clk);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = a;
    if (hold > 0) s_axi_rready = 1'b0;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin chk("arready_timeout", 0, 1); s_axi_arvalid = 1'b0; return; end
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s_axi_rvalid && lat < 100);
    if (!s_axi_rvalid) begin chk("rvalid_timeout", 0, 1); s_axi_rready = 1'b1; return; end
    d = s_axi_rdata;
    r = s_axi_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_rvalid", s_axi_rvalid, 1);
      chk("bp_rdata", s_axi_rdata, d);
      chk("bp_arready", s_axi_arready, 0);
    end
    s_axi_rready = 1'b1;
    @(posedge clk);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        fence;
    logic [63:0] data;
    logic [1:0]  resp;
    int          lat;
    int          nref;
  } vec_t;

  vec_t        vecs [8];
  logic [63:0] d;
  logic [1:0]  r;
  int          lat;
  int          base;
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h8000_0000, 1'b0, 64'h0000_0013_0000_0297, 2'b00, 6, 2}; // cold miss
    vecs[1] = '{64'h8000_0008, 1'b0, 64'h1111_2222_3333_4444, 2'b00, 2, 0}; // hit word 1
    vecs[2] = '{64'h8000_0004, 1'b0, 64'h0000_0013_0000_0297, 2'b00, 2, 0}; // hit word 0
    vecs[3] = '{64'h8000_0100, 1'b0, 64'h7FFF_FEFF_8000_0100, 2'b00, 6, 2}; // conflict evicts
    vecs[4] = '{64'h8000_0000, 1'b0, 64'h0000_0013_0000_0297, 2'b00, 6, 2}; // misses again
    vecs[5] = '{64'h8000_0000, 1'b1, 64'h0000_0013_0000_0297, 2'b00, 6, 2}; // fence while idle
    vecs[6] = '{64'h8000_0010, 1'b0, 64'h7FFF_FFEF_8000_0010, 2'b00, 6, 2}; // index 1 miss
    vecs[7] = '{64'h8000_0018, 1'b0, 64'h7FFF_FFE7_8000_0018, 2'b00, 2, 0}; // index 1 hit

    rst_n = 1'b0; fence_i = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_rready = 1'b1;
    #12;
    chk("rst_s_arready", s_axi_arready, 1);
    chk("rst_s_rvalid", s_axi_rvalid, 0);
    chk("rst_s_rdata", s_axi_rdata, 0);
    chk("rst_s_rresp", s_axi_rresp, 0);
    chk("rst_m_arvalid", m_axi_arvalid, 0);
    chk("rst_m_araddr", m_axi_araddr, 0);
    chk("rst_m_rready", m_axi_rready, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 8; i++) begin
      if (vecs[i].fence) begin
        @(negedge clk);
        fence_i = 1'b1;
        #1 chk("fence_arready", s_axi_arready, 0);
        @(negedge clk);
        fence_i = 1'b0;
      end
      base = ar_cnt;
      fetch(vecs[i].addr, 0, d, r, lat);
      chk($sformatf("v%0d_rdata", i), d, vecs[i].data);
      chk($sformatf("v%0d_rresp", i), r, vecs[i].resp);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_refills", i), ar_cnt - base, vecs[i].nref);
      if (vecs[i].nref == 2 && base + 1 < 64) begin
        chk($sformatf("v%0d_araddr0", i), ar_log[base], {vecs[i].addr[63:4], 4'h0});
        chk($sformatf("v%0d_araddr1", i), ar_log[base+1], {vecs[i].addr[63:4], 4'h8});
      end
    end
    chk("tbl_hit_cnt", hit_cnt, 3);
    chk("tbl_miss_cnt", miss_cnt, 5);

    // fence_i pulsed during MISS_R: data still returned, line left invalid.
    fork
      fetch(64'h8000_0020, 0, d, r, lat);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!m_axi_rready && n < 50);
        chk("fence_saw_mrready", m_axi_rready, 1);
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
      end
    join
    chk("fmr_rdata", d, 64'h7FFF_FFDF_8000_0020);
    chk("fmr_rresp", r, 0);
    chk("fmr_lat", lat, 6);
    base = ar_cnt;
    fetch(64'h8000_0020, 0, d, r, lat);
    chk("fmr_refetch_refills", ar_cnt - base, 2);
    chk("fmr_refetch_lat", lat, 6);

    // Refill error on beat 1: code propagated, line never validated.
    err_addr = 64'h8000_0038;
    fetch(64'h8000_0030, 0, d, r, lat);
    chk("err_rdata", d, 64'h7FFF_FFCF_8000_0030);
    chk("err_rresp", r, 2'b10);
    base = ar_cnt;
    fetch(64'h8000_0030, 0, d, r, lat);
    chk("err_refetch_refills", ar_cnt - base, 2);
    chk("err_refetch_rresp", r, 2'b10);
    err_addr = '1;

    // Backpressure: rready low for 5 cycles.
    fetch(64'h8000_0040, 5, d, r, lat);
    chk("bp_final_rdata", d, 64'h7FFF_FFBF_8000_0040);
    chk("pre_rst_hit_cnt", hit_cnt, 3);
    chk("pre_rst_miss_cnt", miss_cnt, 10);

    // Reset while parked in MISS_AR.
    mem_arready = 1'b0;
    @(negedge clk);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = 64'h8000_0000;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_axi_arvalid && n < 20);
    chk("rst_pre_m_arvalid", m_axi_arvalid, 1);
    s_axi_arvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_arvalid", m_axi_arvalid, 0);
    chk("rst_mid_m_araddr", m_axi_araddr, 0);
    chk("rst_mid_s_arready", s_axi_arready, 1);
    chk("rst_mid_miss_cnt", miss_cnt, 0);
    chk("rst_mid_hit_cnt", hit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_arready = 1'b1;
    base = ar_cnt;
    fetch(64'h8000_0000, 0, d, r, lat);
    chk("post_rst_refills", ar_cnt - base, 2);
    chk("post_rst_rdata", d, 64'h0000_0013_0000_0297);
    chk("post_rst_miss_cnt", miss_cnt, 1);
    chk("post_rst_hit_cnt", hit_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
